// File: rtl/uart_mmio_if.sv
// Core data-bus port bundle (mem_*) shared by the console UART and the bus master driving it.
interface uart_mmio_if;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] rdata;

  modport master (
    output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    input  rdata
  );

  modport slave (
    input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    output rdata
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 console UART: DATA at BASE_ADDR, STATUS at BASE_ADDR+0x10.
// TX shifter, oversampled-by-count RX with one-byte holding register, sticky flags.
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
  parameter int          CLK_DIV   = 868
) (
  input  logic        clk,
  input  logic        rstn,
  uart_mmio_if.slave  bus,
  input  logic        rx,
  output logic        tx
);

  localparam logic [15:0] DIV_LAST_C  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST_C = 16'(CLK_DIV / 2 - 1);
  localparam logic [31:0] STAT_ADDR_C = BASE_ADDR + 32'h0000_0010;

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                            RX_WAIT_HIGH = 3'd4} rx_state_t;

  tx_state_t   tx_state_r, tx_state_n;
  logic [15:0] tx_cnt_r, tx_cnt_n;
  logic [2:0]  tx_bit_r, tx_bit_n;
  logic [7:0]  tx_shift_r, tx_shift_n;
  logic        tx_r, tx_n;

  rx_state_t   rx_state_r, rx_state_n;
  logic [15:0] rx_cnt_r, rx_cnt_n;
  logic [2:0]  rx_bit_r, rx_bit_n;
  logic [7:0]  rx_shift_r, rx_shift_n;
  logic        rx_meta_r, rx_sync_r;
  logic        rx_done_s, rx_ferr_s;

  logic [7:0]  rx_data_r;
  logic        rx_valid_r, overrun_r, frame_err_r;
  logic [31:0] rdata_r;

  logic rd_s, wr_s, data_sel_s, stat_sel_s, data_rd_s;
  logic tx_ready_s, tx_go_s, tx_last_s, rx_last_s, ferr_clr_s;
  logic [31:0] status_s;
  logic unused_bits_s;

  assign rd_s       = bus.mem_valid & ~bus.mem_write;
  assign wr_s       = bus.mem_valid & bus.mem_write;
  assign data_sel_s = (bus.mem_addr == BASE_ADDR);
  assign stat_sel_s = (bus.mem_addr == STAT_ADDR_C);
  assign data_rd_s  = rd_s & data_sel_s;
  assign tx_ready_s = (tx_state_r == TX_IDLE);
  assign tx_go_s    = wr_s & data_sel_s & bus.mem_wmask[0] & tx_ready_s;
  assign ferr_clr_s = wr_s & stat_sel_s & bus.mem_wmask[0] & bus.mem_wdata[3];
  assign tx_last_s  = (tx_cnt_r == DIV_LAST_C);
  assign rx_last_s  = (rx_cnt_r == DIV_LAST_C);
  assign status_s   = {28'h0, frame_err_r, overrun_r, rx_valid_r, tx_ready_s};
  assign unused_bits_s = &{1'b0, bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

  assign tx       = tx_r;
  assign bus.rdata = rdata_r;

  // TX next-state: tx is registered, so the start bit appears the cycle after acceptance
  always_comb begin
    tx_state_n = tx_state_r;
    tx_cnt_n   = tx_cnt_r;
    tx_bit_n   = tx_bit_r;
    tx_shift_n = tx_shift_r;
    tx_n       = tx_r;
    case (tx_state_r)
      TX_IDLE: begin
        tx_n     = 1'b1;
        tx_cnt_n = 16'd0;
        if (tx_go_s) begin
          tx_state_n = TX_START;
          tx_shift_n = bus.mem_wdata[7:0];
          tx_n       = 1'b0;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_last_s) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = 16'd0;
          tx_bit_n   = 3'd0;
          tx_n       = tx_shift_r[0];
          tx_shift_n = {1'b0, tx_shift_r[7:1]};
        end else begin
          tx_cnt_n = tx_cnt_r + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_last_s) begin
          tx_cnt_n = 16'd0;
          if (tx_bit_r == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_bit_n   = tx_bit_r + 3'd1;
            tx_n       = tx_shift_r[0];
            tx_shift_n = {1'b0, tx_shift_r[7:1]};
          end
        end else begin
          tx_cnt_n = tx_cnt_r + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_last_s) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = 16'd0;
          tx_n       = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt_r + 16'd1;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = 16'd0;
        tx_n       = 1'b1;
      end
    endcase
  end

  // TX state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_r       <= 1'b1;
    end else begin
      tx_state_r <= tx_state_n;
      tx_cnt_r   <= tx_cnt_n;
      tx_bit_r   <= tx_bit_n;
      tx_shift_r <= tx_shift_n;
      tx_r       <= tx_n;
    end
  end

  // RX next-state: half-bit wait to mid start bit, then one sample per bit period
  always_comb begin
    rx_state_n = rx_state_r;
    rx_cnt_n   = rx_cnt_r;
    rx_bit_n   = rx_bit_r;
    rx_shift_n = rx_shift_r;
    rx_done_s  = 1'b0;
    rx_ferr_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_n = 16'd0;
        rx_bit_n = 3'd0;
        if (!rx_sync_r) rx_state_n = RX_START;
        else            rx_state_n = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST_C) begin
          rx_cnt_n = 16'd0;
          if (rx_sync_r) rx_state_n = RX_IDLE;
          else           rx_state_n = RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt_r + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_last_s) begin
          rx_cnt_n   = 16'd0;
          rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) rx_state_n = RX_STOP;
          else                  rx_bit_n   = rx_bit_r + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt_r + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_last_s) begin
          rx_cnt_n = 16'd0;
          if (rx_sync_r) begin
            rx_done_s  = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_ferr_s  = 1'b1;
            rx_state_n = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_n = rx_cnt_r + 16'd1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_r) rx_state_n = RX_IDLE;
        else           rx_state_n = RX_WAIT_HIGH;
      end
      default: begin
        rx_state_n = RX_IDLE;
        rx_cnt_n   = 16'd0;
      end
    endcase
  end

  // RX synchronizer and state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      rx_meta_r  <= rx;
      rx_sync_r  <= rx_meta_r;
      rx_state_r <= rx_state_n;
      rx_cnt_r   <= rx_cnt_n;
      rx_bit_r   <= rx_bit_n;
      rx_shift_r <= rx_shift_n;
    end
  end

  // Read data, holding register and flags; reads see the pre-edge values
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_r     <= 32'h0;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (rd_s) begin
        if (data_sel_s)      rdata_r <= {24'h0, rx_data_r};
        else if (stat_sel_s) rdata_r <= status_s;
        else                 rdata_r <= 32'h0;
      end
      if (rx_done_s) begin
        rx_data_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
        overrun_r  <= data_rd_s ? 1'b0 : (overrun_r | rx_valid_r);
      end else if (data_rd_s) begin
        rx_valid_r <= 1'b0;
        overrun_r  <= 1'b0;
      end
      if (rx_ferr_s)       frame_err_r <= 1'b1;
      else if (ferr_clr_s) frame_err_r <= 1'b0;
    end
  end

endmodule
